perf_counter_bank: RTL
======================

Name: perf_counter_bank

Overview:
- Parametrised hardware performance-counter bank for the pipelined processor datapath.
- Generalises the fixed 19-bit stall/arithmetic/memory/CPI registers into three blocks:
  - NUM_EV event counters of configurable width.
  - A free-running cycle counter and a retired-instruction counter.
  - A shadow snapshot bank.
- Adds wrap/saturate mode, sticky overflow flags, freeze-on-finish and a registered read port, so software or the bench can read consistent values after program end.

Parameters:
- NUM_EV, 3, number of event channels (ch0 = stall, ch1 = arithmetic, ch2 = memory by datapath convention).
- WIDTH, 19, bit width of every counter and of rd_data.
- SAT_MODE, 1: 1 = saturate at 2^WIDTH-1; 0 = wrap to 0.
- SELW, $clog2(NUM_EV+2), width of rd_sel.

Ports:
- clkFPGA  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global count enable.
- finish  in  1  program-complete level from datapath; freezes the bank.
- clr  in  1  synchronous clear of live counters, overflow flags and frozen.
- snap  in  1  copy all live counters into shadow bank.
- ev_inc  in  NUM_EV  per-channel increment request, one bit per channel per cycle.
- retire  in  1  one instruction retired this cycle.
- rd_sel  in  SELW  index to read: 0..NUM_EV-1 = events, NUM_EV = cycles, NUM_EV+1 = retired.
- rd_shadow  in  1  1 = read shadow bank, 0 = read live bank.
- rd_data  out  WIDTH  registered read data.
- ovf  out  NUM_EV+2  sticky overflow flag per counter, same indexing as rd_sel.
- frozen  out  1  bank frozen by finish.

Behaviour:
- Reset (rst=0, async): all live and shadow counters = 0, ovf = 0, frozen = 0, rd_data = 0. Reset mid-count discards all values immediately, without waiting for a clock edge.
- Count gate: cnt_ok = en & ~frozen & ~finish. When finish is high in a cycle, that cycle is not counted.
- Event channel i: +1 at the edge when cnt_ok & ev_inc[i].
- Cycle counter: +1 every edge with cnt_ok.
- Retired counter: +1 at the edge when cnt_ok & retire.
- Increment is at most 1 per counter per cycle; no multi-bit adds.
- Overflow with counter at 2^WIDTH-1 and an increment due:
  - SAT_MODE=1: value holds at max and ovf[i] is set.
  - SAT_MODE=0: value becomes 0 and ovf[i] is set.
  - ovf stays set until clr or reset.
- Freeze: at the first edge where finish=1 and frozen=0:
  - frozen ← 1.
  - Shadow bank auto-captures the live values, which are not incremented that cycle.
  - frozen stays 1 while finish deasserts; only clr or reset releases it.
- clr: at the edge, live counters ← 0, ovf ← 0, frozen ← 0; the shadow bank is untouched. clr has priority over increments in the same cycle.
  - clr & finish in the same cycle: clr wins; frozen stays 0 and there is no auto-capture.
- snap: shadow ← current live register values, i.e. pre-increment values at that edge.
  - snap & clr in the same cycle: shadow gets the pre-clear values and live clears (atomic read-and-clear).
  - snap while frozen: shadow recaptures the frozen values.
- Read port: rd_data ← selected register one edge after rd_sel/rd_shadow are sampled, giving 1-cycle latency.
  - The value returned is the register content before any update at that same edge.
  - rd_sel > NUM_EV+1 returns 0.
- Arithmetic: unsigned, WIDTH bits; no carry beyond WIDTH except through ovf.
- No handshake on inputs; every input is sampled every cycle.

Test Plan:
- Reset then en=1, ev_inc=3'b011 for 10 cycles, retire every other cycle → live ch0=10, ch1=10, ch2=0, cycles=10, retired=5. With rd_sel=3, rd_data reads 10 one cycle later.
- WIDTH=4, SAT_MODE=1, ev_inc[0]=1 for 20 cycles → ch0 holds 15, ovf[0]=1. The same test with SAT_MODE=0 → ch0=4, ovf[0]=1.
- Count 7 cycles, raise finish with ev_inc=all-1s → frozen=1 next edge, cycles=7, shadow cycles=7. Drop finish and count 5 more cycles → values unchanged.
- Live ch2=9, assert snap & clr together → shadow ch2=9, live ch2=0, ovf=0. Read with rd_shadow=1, rd_sel=2 → 9.
- Drive rst low mid-count, asynchronously between clock edges → all counters, ovf, frozen and rd_data are 0 before the next clock edge.
- rd_sel=NUM_EV+2 → rd_data=0. clr asserted in the same cycle as finish → frozen stays 0, shadow unchanged.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Performance-counter bank: event, cycle and retired-instruction counters
// with shadow snapshots, overflow flags, freeze-on-finish and a read port.
module perf_counter_bank #(
   parameter int NUM_EV   = 3,
   parameter int WIDTH    = 19,
   parameter int SAT_MODE = 1,
   parameter int SELW     = $clog2(NUM_EV+2)
) (
   input  logic              clkFPGA,
   input  logic              rst,
   input  logic              en,
   input  logic              finish,
   input  logic              clr,
   input  logic              snap,
   input  logic [NUM_EV-1:0] ev_inc,
   input  logic              retire,
   input  logic [SELW-1:0]   rd_sel,
   input  logic              rd_shadow,
   output logic [WIDTH-1:0]  rd_data,
   output logic [NUM_EV+1:0] ovf,
   output logic              frozen
);

   localparam int NC = NUM_EV + 2;
   localparam logic [WIDTH-1:0] MAXV = '1;

   logic [WIDTH-1:0] cnt_q [NC];
   logic [WIDTH-1:0] cnt_d [NC];
   logic [WIDTH-1:0] shd_q [NC];
   logic [WIDTH-1:0] shd_d [NC];
   logic [NC-1:0]    ovf_q, ovf_d, inc;
   logic             frozen_q, frozen_d;
   logic [WIDTH-1:0] rd_q, rd_d;
   logic             cnt_ok, freeze, capture;

   always_comb begin
      cnt_ok   = en & ~frozen_q & ~finish;
      freeze   = finish & ~frozen_q & ~clr;
      capture  = snap | freeze;
      // Channel order: events, then cycles, then retired.
      inc      = {retire, 1'b1, ev_inc} & {NC{cnt_ok}};
      ovf_d    = ovf_q;
      frozen_d = frozen_q | freeze;
      rd_d     = '0;
      for (int i = 0; i < NC; i++) begin
         shd_d[i] = capture ? cnt_q[i] : shd_q[i];
         cnt_d[i] = cnt_q[i];
         if (clr) begin
            cnt_d[i] = '0;
         end else if (inc[i]) begin
            if (cnt_q[i] == MAXV) begin
               ovf_d[i] = 1'b1;
               cnt_d[i] = (SAT_MODE != 0) ? MAXV : '0;
            end else begin
               cnt_d[i] = cnt_q[i] + WIDTH'(1);
            end
         end
         if (rd_sel == SELW'(i))
            rd_d = rd_shadow ? shd_q[i] : cnt_q[i];
      end
      if (clr) begin
         ovf_d    = '0;
         frozen_d = 1'b0;
      end
   end

   always_ff @(posedge clkFPGA or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NC; i++) begin
            cnt_q[i] <= '0;
            shd_q[i] <= '0;
         end
         ovf_q    <= '0;
         frozen_q <= 1'b0;
         rd_q     <= '0;
      end else begin
         for (int i = 0; i < NC; i++) begin
            cnt_q[i] <= cnt_d[i];
            shd_q[i] <= shd_d[i];
         end
         ovf_q    <= ovf_d;
         frozen_q <= frozen_d;
         rd_q     <= rd_d;
      end
   end

   assign rd_data = rd_q;
   assign ovf     = ovf_q;
   assign frozen  = frozen_q;

endmodule
